mem_port_arb: RTL and testbench



---
 rtl/mem_port_arb_pkg.sv | 21 ++
 rtl/mem_arb_rr.sv | 46 ++++
 rtl/mem_port_arb.sv | 176 +++++++++++++++++
 tb/tb_mem_port_arb.sv | 489 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arb_pkg.sv
// mem_port_arb_pkg
//   Shared definitions for the two-master memory port arbiter:
//   the arbiter state encoding and the grant identifiers used by
//   mem_port_arb and its round-robin helper mem_arb_rr.
package mem_port_arb_pkg;

    localparam int MEM_ARB_ST_BITS = 3;

    typedef enum logic [MEM_ARB_ST_BITS-1:0] {
        ST_IDLE      = 3'd0,   // arbitrating, nothing outstanding
        ST_D_WR      = 3'd1,   // data write presented to the slave
        ST_D_RD_CMD  = 3'd2,   // data read command presented to the slave
        ST_D_RD_WAIT = 3'd3,   // waiting for the single data read beat
        ST_I_CMD     = 3'd4,   // inst burst command presented to the slave
        ST_I_BURST   = 3'd5    // collecting inst burst beats
    } arb_state_t;

    localparam logic GRANT_INST = 1'b0;
    localparam logic GRANT_DATA = 1'b1;

endpackage

// File: rtl/mem_arb_rr.sv
// mem_arb_rr
//   Two-requester round-robin grant. The grant is combinational from the
//   request lines; last_grant remembers the winner of the most recent
//   accepted arbitration so that on a tie the other requester wins.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   req_inst      instruction master is requesting
//   req_data      data master is requesting
//   update        the caller is committing to this cycle's grant
//   grant_valid   at least one requester is present
//   grant         winner (GRANT_INST / GRANT_DATA), meaningful with grant_valid
//   last_grant    winner of the last committed arbitration
module mem_arb_rr
    import mem_port_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_inst,
    input  logic req_data,
    input  logic update,
    output logic grant_valid,
    output logic grant,
    output logic last_grant
);

    always_comb begin
        grant_valid = req_inst | req_data;
        if (req_inst && req_data) begin
            grant = ~last_grant;
        end else if (req_data) begin
            grant = GRANT_DATA;
        end else begin
            grant = GRANT_INST;
        end
    end

    // Reset to INST so the data master wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= GRANT_INST;
        end else if (update && grant_valid) begin
            last_grant <= grant;
        end
    end

endmodule

// File: rtl/mem_port_arb.sv
// mem_port_arb
//   Merges the CPU instruction master (burst reads) and data master
//   (single-beat reads/writes) onto one Avalon-MM slave port. One
//   transaction is outstanding at a time; ties are broken round-robin.
//
//   Handshake: a command transfers on a clock edge where o_mem_read or
//   o_mem_write is high and i_mem_waitrequest is low; the granted master
//   sees its waitrequest low in exactly that cycle. Read beats transfer on
//   edges where i_mem_readdatavalid is high and are forwarded with no
//   added latency to the master that owns the outstanding read.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   i_inst_*/o_inst_*           instruction master (read, burstcount)
//   i_data_*/o_data_*           data master (read, write, writedata)
//   o_mem_*/i_mem_*             slave port
module mem_port_arb
    import mem_port_arb_pkg::*;
#(
    parameter int P_WORD_BITS  = 32,
    parameter int P_ADDR_BITS  = 32,
    parameter int P_BURST_BITS = 8
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic [P_ADDR_BITS-1:0]  i_inst_addr,
    input  logic                    i_inst_read,
    input  logic [P_WORD_BITS-1:0]  i_inst_burstcount,
    output logic                    o_inst_waitrequest,
    output logic [P_WORD_BITS-1:0]  o_inst_readdata,
    output logic                    o_inst_readdatavalid,

    input  logic [P_ADDR_BITS-1:0]  i_data_addr,
    input  logic                    i_data_read,
    input  logic                    i_data_write,
    input  logic [P_WORD_BITS-1:0]  i_data_writedata,
    output logic                    o_data_waitrequest,
    output logic [P_WORD_BITS-1:0]  o_data_readdata,
    output logic                    o_data_readdatavalid,

    output logic [P_ADDR_BITS-1:0]  o_mem_addr,
    output logic                    o_mem_read,
    output logic                    o_mem_write,
    output logic [P_WORD_BITS-1:0]  o_mem_writedata,
    output logic [P_BURST_BITS-1:0] o_mem_burstcount,
    input  logic                    i_mem_waitrequest,
    input  logic [P_WORD_BITS-1:0]  i_mem_readdata,
    input  logic                    i_mem_readdatavalid
);

    arb_state_t state, state_next;

    logic                    data_req;
    logic                    grant_valid;
    logic                    grant;
    logic                    last_grant;
    logic                    arb_en;
    logic [P_BURST_BITS-1:0] inst_burst_raw;
    logic [P_BURST_BITS-1:0] inst_burst;
    logic [P_BURST_BITS-1:0] beat_cnt;
    logic                    unused_burst_hi;

    assign data_req = i_data_read | i_data_write;
    assign arb_en   = (state == ST_IDLE);

    // The slave burstcount is narrower than the master's; the upper bits
    // are dropped, and a resulting zero is promoted to a single beat.
    assign inst_burst_raw  = i_inst_burstcount[P_BURST_BITS-1:0];
    assign inst_burst      = (inst_burst_raw == '0) ? P_BURST_BITS'(1) : inst_burst_raw;
    assign unused_burst_hi = ^i_inst_burstcount[P_WORD_BITS-1:P_BURST_BITS];

    mem_arb_rr u_rr (
        .clk         (clk),
        .rst         (rst),
        .req_inst    (i_inst_read),
        .req_data    (data_req),
        .update      (arb_en),
        .grant_valid (grant_valid),
        .grant       (grant),
        .last_grant  (last_grant)
    );

    // Read data goes to both masters; only readdatavalid is steered.
    assign o_inst_readdata = i_mem_readdata;
    assign o_data_readdata = i_mem_readdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Command fields are captured at grant time so they stay stable for
    // the whole command phase regardless of what the masters do.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_mem_addr       <= '0;
            o_mem_writedata  <= '0;
            o_mem_burstcount <= '0;
        end else if (arb_en && grant_valid) begin
            if (grant == GRANT_DATA) begin
                o_mem_addr       <= i_data_addr;
                o_mem_writedata  <= i_data_writedata;
                o_mem_burstcount <= P_BURST_BITS'(1);
            end else begin
                o_mem_addr       <= i_inst_addr;
                o_mem_burstcount <= inst_burst;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt <= '0;
        end else if (state == ST_I_CMD && !i_mem_waitrequest) begin
            beat_cnt <= o_mem_burstcount;
        end else if (state == ST_I_BURST && i_mem_readdatavalid) begin
            beat_cnt <= beat_cnt - P_BURST_BITS'(1);
        end
    end

    always_comb begin
        state_next           = state;
        o_mem_read           = 1'b0;
        o_mem_write          = 1'b0;
        o_inst_waitrequest   = 1'b1;
        o_data_waitrequest   = 1'b1;
        o_inst_readdatavalid = 1'b0;
        o_data_readdatavalid = 1'b0;

        case (state)
            ST_IDLE: begin
                if (grant_valid) begin
                    if (grant == GRANT_DATA) begin
                        // Write wins if a master illegally raises both.
                        state_next = i_data_write ? ST_D_WR : ST_D_RD_CMD;
                    end else begin
                        state_next = ST_I_CMD;
                    end
                end
            end
            ST_D_WR: begin
                o_mem_write        = 1'b1;
                o_data_waitrequest = i_mem_waitrequest;
                if (!i_mem_waitrequest) state_next = ST_IDLE;
            end
            ST_D_RD_CMD: begin
                o_mem_read         = 1'b1;
                o_data_waitrequest = i_mem_waitrequest;
                if (!i_mem_waitrequest) state_next = ST_D_RD_WAIT;
            end
            ST_D_RD_WAIT: begin
                o_data_readdatavalid = i_mem_readdatavalid;
                if (i_mem_readdatavalid) state_next = ST_IDLE;
            end
            ST_I_CMD: begin
                o_mem_read         = 1'b1;
                o_inst_waitrequest = i_mem_waitrequest;
                if (!i_mem_waitrequest) state_next = ST_I_BURST;
            end
            ST_I_BURST: begin
                o_inst_readdatavalid = i_mem_readdatavalid;
                if (i_mem_readdatavalid && beat_cnt == P_BURST_BITS'(1)) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_port_arb.sv
// tb_mem_port_arb
//   Self-checking bench for mem_port_arb: directed scenarios with literal
//   expectations plus randomized traffic, all compared every cycle against
//   a transaction-level model of the arbiter.
module tb_mem_port_arb;

    localparam int W = 32;
    localparam int A = 32;
    localparam int B = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    logic [A-1:0] i_inst_addr = '0;
    logic         i_inst_read = 1'b0;
    logic [W-1:0] i_inst_burstcount = '0;
    logic         o_inst_waitrequest;
    logic [W-1:0] o_inst_readdata;
    logic         o_inst_readdatavalid;
    logic [A-1:0] i_data_addr = '0;
    logic         i_data_read = 1'b0;
    logic         i_data_write = 1'b0;
    logic [W-1:0] i_data_writedata = '0;
    logic         o_data_waitrequest;
    logic [W-1:0] o_data_readdata;
    logic         o_data_readdatavalid;
    logic [A-1:0] o_mem_addr;
    logic         o_mem_read;
    logic         o_mem_write;
    logic [W-1:0] o_mem_writedata;
    logic [B-1:0] o_mem_burstcount;
    logic         i_mem_waitrequest = 1'b0;
    logic [W-1:0] i_mem_readdata = '0;
    logic         i_mem_readdatavalid = 1'b0;

    mem_port_arb #(.P_WORD_BITS(W), .P_ADDR_BITS(A), .P_BURST_BITS(B)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .i_inst_addr          (i_inst_addr),
        .i_inst_read          (i_inst_read),
        .i_inst_burstcount    (i_inst_burstcount),
        .o_inst_waitrequest   (o_inst_waitrequest),
        .o_inst_readdata      (o_inst_readdata),
        .o_inst_readdatavalid (o_inst_readdatavalid),
        .i_data_addr          (i_data_addr),
        .i_data_read          (i_data_read),
        .i_data_write         (i_data_write),
        .i_data_writedata     (i_data_writedata),
        .o_data_waitrequest   (o_data_waitrequest),
        .o_data_readdata      (o_data_readdata),
        .o_data_readdatavalid (o_data_readdatavalid),
        .o_mem_addr           (o_mem_addr),
        .o_mem_read           (o_mem_read),
        .o_mem_write          (o_mem_write),
        .o_mem_writedata      (o_mem_writedata),
        .o_mem_burstcount     (o_mem_burstcount),
        .i_mem_waitrequest    (i_mem_waitrequest),
        .i_mem_readdata       (i_mem_readdata),
        .i_mem_readdatavalid  (i_mem_readdatavalid)
    );

    // ---------------- bookkeeping ----------------
    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // phase 0: no transaction (arbitrating), 1: command offered to slave,
    // 2: read accepted, beats still owed to the owner.
    int           m_phase;
    bit           m_data_owner;
    bit           m_write;
    bit           m_prefer_data;
    logic [31:0]  m_addr;
    logic [31:0]  m_wdata;
    int           m_burst;
    int           m_left;

    task automatic m_reset();
        m_phase       = 0;
        m_data_owner  = 1'b0;
        m_write       = 1'b0;
        m_prefer_data = 1'b1;
        m_left        = 0;
    endtask

    task automatic m_step();
        bit dreq, ireq, take_data;
        case (m_phase)
            0: begin
                dreq = i_data_read | i_data_write;
                ireq = i_inst_read;
                if (dreq || ireq) begin
                    take_data     = dreq && (!ireq || m_prefer_data);
                    m_data_owner  = take_data;
                    m_prefer_data = !take_data;
                    if (take_data) begin
                        m_write = i_data_write;
                        m_addr  = i_data_addr;
                        m_wdata = i_data_writedata;
                        m_burst = 1;
                    end else begin
                        m_write = 1'b0;
                        m_addr  = i_inst_addr;
                        m_burst = int'(i_inst_burstcount % 256);
                        if (m_burst == 0) m_burst = 1;
                    end
                    m_phase = 1;
                end
            end
            1: begin
                if (!i_mem_waitrequest) begin
                    if (m_write) m_phase = 0;
                    else begin
                        m_phase = 2;
                        m_left  = m_burst;
                    end
                end
            end
            default: begin
                if (i_mem_readdatavalid) begin
                    m_left--;
                    if (m_left == 0) m_phase = 0;
                end
            end
        endcase
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) m_reset();
            else m_step();
        end
    end

    // ---------------- slave model (stimulus) ----------------
    int          pend = 0;
    bit          tog = 1'b0;
    int          stall_left = 0;
    bit          rand_mode = 1'b0;
    logic [31:0] slave_data_q[$];

    initial begin
        forever begin
            @(negedge clk);
            if (i_mem_readdatavalid && pend > 0) pend--;
            if (!rst && o_mem_read && !i_mem_waitrequest) pend += int'(o_mem_burstcount);
            @(posedge clk);
            #1;
            if (rand_mode) begin
                i_mem_waitrequest = ($urandom_range(0, 2) == 0);
            end else if ((o_mem_read || o_mem_write) && stall_left > 0) begin
                i_mem_waitrequest = 1'b1;
                stall_left--;
            end else begin
                i_mem_waitrequest = 1'b0;
            end
            if (pend > 0 && (rand_mode ? ($urandom_range(0, 1) == 1) : tog)) begin
                i_mem_readdatavalid = 1'b1;
                i_mem_readdata = (slave_data_q.size() > 0) ? slave_data_q.pop_front() : $urandom;
            end else begin
                i_mem_readdatavalid = 1'b0;
                i_mem_readdata = $urandom;
            end
            tog = !tog;
        end
    end

    // ---------------- scoreboard + per-cycle compare ----------------
    logic [31:0] exp_inst_q[$];
    logic [31:0] exp_data_q[$];
    bit          sb_en = 1'b0;
    int          cnt_mem_write, cnt_dwait_low, cnt_inst_valid, cnt_data_valid;
    int          last_inst_valid_cyc, data_accept_cyc;
    logic [31:0] last_cmd_addr, last_cmd_wdata, last_cmd_burst, first_cmd_addr;
    bit          cmd_seen;

    task automatic clear_counters();
        cnt_mem_write  = 0;
        cnt_dwait_low  = 0;
        cnt_inst_valid = 0;
        cnt_data_valid = 0;
        cmd_seen       = 1'b0;
    endtask

    initial begin
        bit exp_read, exp_write, exp_iw, exp_dw, exp_iv, exp_dv;
        clear_counters();
        forever begin
            @(negedge clk);
            exp_read  = (m_phase == 1) && !m_write;
            exp_write = (m_phase == 1) && m_write;
            exp_iw    = !((m_phase == 1) && !m_data_owner && !i_mem_waitrequest);
            exp_dw    = !((m_phase == 1) && m_data_owner && !i_mem_waitrequest);
            exp_iv    = (m_phase == 2) && !m_data_owner && i_mem_readdatavalid;
            exp_dv    = (m_phase == 2) && m_data_owner && i_mem_readdatavalid;
            chk("mem_read",   32'(o_mem_read),           32'(exp_read));
            chk("mem_write",  32'(o_mem_write),          32'(exp_write));
            chk("inst_wait",  32'(o_inst_waitrequest),   32'(exp_iw));
            chk("data_wait",  32'(o_data_waitrequest),   32'(exp_dw));
            chk("inst_valid", 32'(o_inst_readdatavalid), 32'(exp_iv));
            chk("data_valid", 32'(o_data_readdatavalid), 32'(exp_dv));
            chk("inst_rdata", o_inst_readdata, i_mem_readdata);
            chk("data_rdata", o_data_readdata, i_mem_readdata);
            if (m_phase == 1) begin
                chk("mem_addr",  o_mem_addr, m_addr);
                chk("mem_burst", 32'(o_mem_burstcount), 32'(m_burst));
                if (m_write) chk("mem_wdata", o_mem_writedata, m_wdata);
            end

            cnt_mem_write  += int'(o_mem_write);
            cnt_dwait_low  += int'(!o_data_waitrequest);
            cnt_inst_valid += int'(o_inst_readdatavalid);
            cnt_data_valid += int'(o_data_readdatavalid);
            if (o_inst_readdatavalid) last_inst_valid_cyc = cyc;
            if (!o_data_waitrequest) data_accept_cyc = cyc;
            if (!cmd_seen && (o_mem_read || o_mem_write)) begin
                cmd_seen       = 1'b1;
                first_cmd_addr = o_mem_addr;
            end
            if ((o_mem_read || o_mem_write) && !i_mem_waitrequest) begin
                last_cmd_addr  = o_mem_addr;
                last_cmd_wdata = o_mem_writedata;
                last_cmd_burst = 32'(o_mem_burstcount);
            end
            if (sb_en && o_inst_readdatavalid) begin
                if (exp_inst_q.size() == 0) chk("inst_extra_beat", 32'(1), 32'(0));
                else chk("inst_beat", o_inst_readdata, exp_inst_q.pop_front());
            end
            if (sb_en && o_data_readdatavalid) begin
                if (exp_data_q.size() == 0) chk("data_extra_beat", 32'(1), 32'(0));
                else chk("data_beat", o_data_readdata, exp_data_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic data_op(input bit wr, input logic [31:0] addr, input logic [31:0] wd);
        int n = 0;
        @(posedge clk);
        #1;
        i_data_addr      = addr;
        i_data_writedata = wd;
        i_data_write     = wr;
        i_data_read      = !wr;
        forever begin
            @(negedge clk);
            if (!o_data_waitrequest) break;
            n++;
            if (n > 500) begin
                chk("data_accept_timeout", 32'(1), 32'(0));
                break;
            end
        end
        @(posedge clk);
        #1;
        i_data_read  = 1'b0;
        i_data_write = 1'b0;
    endtask

    task automatic inst_op(input logic [31:0] addr, input logic [31:0] bc);
        int n = 0;
        @(posedge clk);
        #1;
        i_inst_addr       = addr;
        i_inst_burstcount = bc;
        i_inst_read       = 1'b1;
        forever begin
            @(negedge clk);
            if (!o_inst_waitrequest) break;
            n++;
            if (n > 500) begin
                chk("inst_accept_timeout", 32'(1), 32'(0));
                break;
            end
        end
        @(posedge clk);
        #1;
        i_inst_read = 1'b0;
    endtask

    task automatic wait_quiet();
        int n = 0;
        while (!(pend == 0 && m_phase == 0 && !i_mem_readdatavalid)) begin
            @(negedge clk);
            n++;
            if (n > 3000) begin
                chk("quiet_timeout", 32'(1), 32'(0));
                return;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish in time");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int n;
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mem_read",   32'(o_mem_read), 32'(0));
        chk("rst_mem_write",  32'(o_mem_write), 32'(0));
        chk("rst_mem_addr",   o_mem_addr, 32'(0));
        chk("rst_mem_wdata",  o_mem_writedata, 32'(0));
        chk("rst_mem_burst",  32'(o_mem_burstcount), 32'(0));
        chk("rst_inst_wait",  32'(o_inst_waitrequest), 32'(1));
        chk("rst_data_wait",  32'(o_data_waitrequest), 32'(1));
        chk("rst_inst_valid", 32'(o_inst_readdatavalid), 32'(0));
        chk("rst_data_valid", 32'(o_data_readdatavalid), 32'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb_en = 1'b1;

        // Data write with two slave stall cycles.
        clear_counters();
        stall_left = 2;
        data_op(1'b1, 32'h100, 32'hDEADBEEF);
        wait_quiet();
        chk("wr_cmd_cycles", 32'(cnt_mem_write), 32'(3));
        chk("wr_ack_cycles", 32'(cnt_dwait_low), 32'(1));
        chk("wr_addr",       last_cmd_addr, 32'h100);
        chk("wr_wdata",      last_cmd_wdata, 32'hDEADBEEF);

        // Inst burst of 4 with gaps between beats.
        clear_counters();
        slave_data_q = '{32'h11, 32'h22, 32'h33, 32'h44};
        exp_inst_q   = '{32'h11, 32'h22, 32'h33, 32'h44};
        inst_op(32'h0, 32'd4);
        wait_quiet();
        chk("burst4_beats",      32'(cnt_inst_valid), 32'(4));
        chk("burst4_data_beats", 32'(cnt_data_valid), 32'(0));
        chk("burst4_left",       32'(exp_inst_q.size()), 32'(0));
        chk("burst4_count",      last_cmd_burst, 32'(4));

        // Tie straight out of reset: data first, then the inst burst.
        do_reset();
        clear_counters();
        slave_data_q = '{32'hA5A5A5A5};
        exp_data_q   = '{32'hA5A5A5A5};
        for (int i = 0; i < 8; i++) begin
            slave_data_q.push_back(32'hC0 + 32'(i));
            exp_inst_q.push_back(32'hC0 + 32'(i));
        end
        fork
            data_op(1'b0, 32'h200, 32'h0);
            inst_op(32'h1000, 32'd8);
        join
        wait_quiet();
        chk("tie1_first",      first_cmd_addr, 32'h200);
        chk("tie1_data_beats", 32'(cnt_data_valid), 32'(1));
        chk("tie1_inst_beats", 32'(cnt_inst_valid), 32'(8));
        chk("tie1_left",       32'(exp_inst_q.size() + exp_data_q.size()), 32'(0));

        // Next tie: inst won last, so data wins again.
        clear_counters();
        slave_data_q = '{32'h1234, 32'hD1, 32'hD2};
        exp_data_q   = '{32'h1234};
        exp_inst_q   = '{32'hD1, 32'hD2};
        fork
            data_op(1'b0, 32'h300, 32'h0);
            inst_op(32'h2000, 32'd2);
        join
        wait_quiet();
        chk("tie2_first", first_cmd_addr, 32'h300);
        chk("tie2_left",  32'(exp_inst_q.size() + exp_data_q.size()), 32'(0));

        // Data request raised during an inst burst waits for burst + bubble.
        clear_counters();
        slave_data_q = '{32'hE1, 32'hE2, 32'hE3, 32'hE4, 32'hF00D};
        exp_inst_q   = '{32'hE1, 32'hE2, 32'hE3, 32'hE4};
        exp_data_q   = '{32'hF00D};
        fork
            inst_op(32'h40, 32'd4);
            begin
                n = 0;
                while (m_phase != 2 && n < 200) begin
                    @(negedge clk);
                    n++;
                end
                data_op(1'b0, 32'h500, 32'h0);
            end
        join
        wait_quiet();
        chk("defer_gap",   32'(data_accept_cyc - last_inst_valid_cyc), 32'(2));
        chk("defer_beats", 32'(cnt_inst_valid + cnt_data_valid), 32'(5));

        // Inst burstcount 0 is one beat.
        clear_counters();
        slave_data_q = '{32'h99};
        exp_inst_q   = '{32'h99};
        inst_op(32'h80, 32'd0);
        wait_quiet();
        chk("bc0_count", last_cmd_burst, 32'(1));
        chk("bc0_beats", 32'(cnt_inst_valid), 32'(1));

        // Asynchronous reset after beat 2 of 4; remaining beats dropped.
        clear_counters();
        slave_data_q = '{32'h51, 32'h52, 32'h53, 32'h54};
        exp_inst_q   = '{32'h51, 32'h52};
        inst_op(32'h0, 32'd4);
        n = 0;
        while (cnt_inst_valid < 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        #2;
        rst = 1'b1;
        #1;
        chk("arst_mem_read",   32'(o_mem_read), 32'(0));
        chk("arst_inst_wait",  32'(o_inst_waitrequest), 32'(1));
        chk("arst_inst_valid", 32'(o_inst_readdatavalid), 32'(0));
        chk("arst_data_valid", 32'(o_data_readdatavalid), 32'(0));
        chk("arst_mem_addr",   o_mem_addr, 32'(0));
        chk("arst_mem_burst",  32'(o_mem_burstcount), 32'(0));
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        wait_quiet();
        chk("arst_dropped", 32'(cnt_inst_valid), 32'(2));
        chk("arst_left",    32'(exp_inst_q.size()), 32'(0));
        slave_data_q = '{32'h77};
        exp_data_q   = '{32'h77};
        data_op(1'b0, 32'h600, 32'h0);
        wait_quiet();
        chk("arst_new_read", 32'(cnt_data_valid), 32'(1));

        // Randomized traffic, checked by the per-cycle model.
        sb_en = 1'b0;
        slave_data_q.delete();
        rand_mode = 1'b1;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    logic [31:0] bc;
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    bc = 32'($urandom_range(0, 6));
                    if ($urandom_range(0, 7) == 0) bc = bc + 32'd256;
                    inst_op($urandom, bc);
                end
            end
            begin
                for (int j = 0; j < 80; j++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    data_op(1'($urandom_range(0, 1)), $urandom, $urandom);
                end
            end
        join
        rand_mode = 1'b0;
        wait_quiet();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
